// File: rtl/dcache_ctrl_pkg.sv
// Shared types and sizing for the direct-mapped data cache controller.
// Address layout: tag [31:5] | index [4:2] | byte offset [1:0].
package dcache_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SET_SIZE   = 3;
    localparam int SETS       = 2 ** SET_SIZE;
    localparam int TAG_WIDTH  = DATA_WIDTH - SET_SIZE - 2;
    localparam int CNT_WIDTH  = 16;
    localparam int LANES      = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FMT_WORD = 2'b00,
        FMT_HALF = 2'b01,
        FMT_BYTE = 2'b10
    } byte_format_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } dcache_state_e;

    typedef struct packed {
        logic                  v;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cache_block_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [DATA_WIDTH-1:0] a);
        return a[DATA_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic logic [SET_SIZE-1:0] addr_idx(input logic [DATA_WIDTH-1:0] a);
        return a[SET_SIZE+1:2];
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache controller.
// master is the cache controller; slave is the pipeline/memory environment.
interface dcache_ctrl_if;

    logic                                  cpu_req_i;
    logic                                  cpu_we_i;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] cpu_addr_i;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] cpu_wdata_i;
    logic [1:0]                            cpu_byte_i;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] cpu_rdata_o;
    logic                                  cpu_ready_o;

    logic                                  mem_req_o;
    logic                                  mem_we_o;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] mem_addr_o;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] mem_wdata_o;
    logic [dcache_ctrl_pkg::LANES-1:0]      mem_be_o;
    logic                                  mem_ack_i;
    logic [dcache_ctrl_pkg::DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_byte_i,
        input  mem_ack_i, mem_rdata_i,
        output cpu_rdata_o, cpu_ready_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_byte_i,
        output mem_ack_i, mem_rdata_i,
        input  cpu_rdata_o, cpu_ready_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

endinterface

// File: rtl/dcache_ctrl_byte_lane_gen.sv
// Byte-enable and lane-shift generation for stores; format 11 falls back to a word.
// Bytes outside the enabled lanes are driven to zero.
module byte_lane_gen
    import dcache_ctrl_pkg::*;
(
    input  logic [1:0]            fmt,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [LANES-1:0]      be,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        be   = '1;
        data = wdata;
        case (fmt)
            FMT_HALF: begin
                be   = offset[1] ? 4'b1100 : 4'b0011;
                data = offset[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
            end
            FMT_BYTE: begin
                be   = 4'b0001 << offset;
                data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << {offset, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete combinationally in IDLE; misses and stores stall until memory acks.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o,
    dcache_ctrl_if.master        bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]            state;
    cache_block_t          blocks [SETS];
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  req_we;
    logic [1:0]            req_fmt;
    logic                  flush_pend;

    logic [SET_SIZE-1:0]   cpu_idx, req_idx;
    logic [TAG_WIDTH-1:0]  cpu_tag, req_tag;
    logic                  cpu_hit, req_hit;
    logic                  idle, load_hit, load_miss;
    logic                  fetch_active, write_active, mem_active;
    logic [LANES-1:0]      lane_be;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] merge_word;

    assign cpu_idx = addr_idx(bus.cpu_addr_i);
    assign cpu_tag = addr_tag(bus.cpu_addr_i);
    assign req_idx = addr_idx(req_addr);
    assign req_tag = addr_tag(req_addr);

    assign cpu_hit = blocks[cpu_idx].v && (blocks[cpu_idx].tag == cpu_tag);
    assign req_hit = blocks[req_idx].v && (blocks[req_idx].tag == req_tag);

    // A flush in IDLE wins over the request, so nothing is served that cycle.
    assign idle      = (state == S_IDLE);
    assign load_hit  = idle && !flush_i && bus.cpu_req_i && !bus.cpu_we_i && cpu_hit;
    assign load_miss = idle && !flush_i && bus.cpu_req_i && !bus.cpu_we_i && !cpu_hit;

    assign fetch_active = (state == S_FETCH);
    assign write_active = (state == S_WRITE);
    assign mem_active   = fetch_active || write_active;

    byte_lane_gen u_lane (
        .fmt    (req_fmt),
        .offset (req_addr[1:0]),
        .wdata  (req_wdata),
        .be     (lane_be),
        .data   (lane_data)
    );

    always_comb begin
        merge_word = blocks[req_idx].data;
        for (int b = 0; b < LANES; b++) begin
            if (lane_be[b]) merge_word[8*b +: 8] = lane_data[8*b +: 8];
        end
    end

    // Memory outputs come straight from latched request state, so they hold until ack.
    assign bus.mem_req_o   = mem_active;
    assign bus.mem_we_o    = write_active;
    assign bus.mem_addr_o  = mem_active ? {req_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_be_o    = write_active ? lane_be : '0;
    assign bus.mem_wdata_o = write_active ? lane_data : '0;

    assign bus.cpu_ready_o = load_hit || (state == S_RESP);
    assign bus.cpu_rdata_o = load_hit ? blocks[cpu_idx].data :
                             (state == S_RESP) ? resp_data : '0;
    assign stall_o = mem_active || (idle && (flush_i || (bus.cpu_req_i && !load_hit)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_we     <= 1'b0;
            req_fmt    <= '0;
            resp_data  <= '0;
            flush_pend <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            for (int s = 0; s < SETS; s++) blocks[s] <= '0;
        end else begin
            if (load_hit && (hit_cnt_o != '1))   hit_cnt_o  <= hit_cnt_o + 1'b1;
            if (load_miss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 1'b1;

            case (state)
                S_IDLE: begin
                    if (flush_i) begin
                        for (int s = 0; s < SETS; s++) blocks[s].v <= 1'b0;
                    end else if (bus.cpu_req_i && !load_hit) begin
                        req_addr  <= bus.cpu_addr_i;
                        req_wdata <= bus.cpu_wdata_i;
                        req_we    <= bus.cpu_we_i;
                        req_fmt   <= bus.cpu_byte_i;
                        state     <= bus.cpu_we_i ? S_WRITE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (flush_i) flush_pend <= 1'b1;
                    if (bus.mem_ack_i) begin
                        blocks[req_idx] <= {1'b1, req_tag, bus.mem_rdata_i};
                        resp_data       <= bus.mem_rdata_i;
                        state           <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (flush_i) flush_pend <= 1'b1;
                    if (bus.mem_ack_i) begin
                        if (req_hit) blocks[req_idx].data <= merge_word;
                        resp_data <= '0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush_pend || flush_i) begin
                        for (int s = 0; s < SETS; s++) blocks[s].v <= 1'b0;
                    end
                    flush_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed, table-driven bench for dcache_ctrl with hand-written multi-cycle sequences.
// Each table row is one clock cycle: inputs driven, outputs expected before the edge.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dcache_ctrl_if bus();

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .stall_o    (stall),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  fmt;
        logic        flush;
        logic        ack;
        logic [31:0] mrd;
        logic        rdy;
        logic        stl;
        logic        mrq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  be;
        logic [31:0] rd;
        int          hit;
        int          miss;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [1:0] fmt, input logic fl, input logic ack, input logic [31:0] mrd,
        input logic rdy, input logic stl, input logic mrq, input logic mwe,
        input logic [31:0] maddr, input logic [31:0] mwd, input logic [3:0] be,
        input logic [31:0] rd, input int hit, input int miss);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.fmt = fmt;
        v.flush = fl; v.ack = ack; v.mrd = mrd;
        v.rdy = rdy; v.stl = stl; v.mrq = mrq; v.mwe = mwe; v.maddr = maddr;
        v.mwd = mwd; v.be = be; v.rd = rd; v.hit = hit; v.miss = miss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] fmt,
                         input logic fl, input logic ack, input logic [31:0] mrd);
        bus.cpu_req_i   = req;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        bus.cpu_byte_i  = fmt;
        flush           = fl;
        bus.mem_ack_i   = ack;
        bus.mem_rdata_i = mrd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset.mem_req",  32'(bus.mem_req_o), 0);
        chk("reset.stall",    32'(stall), 0);
        chk("reset.ready",    32'(bus.cpu_ready_o), 0);
        chk("reset.rdata",    bus.cpu_rdata_o, 0);
        chk("reset.mem_addr", bus.mem_addr_o, 0);
        chk("reset.hit_cnt",  32'(hit_cnt), 0);
        chk("reset.miss_cnt", 32'(miss_cnt), 0);
        rst = 1'b0;

        //          req we addr       wdata         fmt fl ack mrd             rdy stl mrq mwe maddr      mwd           be       rd          hit miss
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            0, 0));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            0, 1, 1, 0, 32'h104,   0,            4'b0000, 0,            0, 1));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 1, 32'hDEADBEEF, 0, 1, 1, 0, 32'h104,   0,            4'b0000, 0,            0, 1));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(1, 1, 32'h106, 32'hAA,       2, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            1, 1));
        tbl.push_back(mk(1, 1, 32'h106, 32'hAA,       2, 0, 0, 0,            0, 1, 1, 1, 32'h104,   32'h00AA0000, 4'b0100, 0,            1, 1));
        tbl.push_back(mk(1, 1, 32'h106, 32'hAA,       2, 0, 1, 0,            0, 1, 1, 1, 32'h104,   32'h00AA0000, 4'b0100, 0,            1, 1));
        tbl.push_back(mk(1, 1, 32'h106, 32'hAA,       2, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 0,            1, 1));
        tbl.push_back(mk(1, 0, 32'h106, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hDEAABEEF, 1, 1));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            2, 1));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 1, 32'h12345678, 0, 1, 1, 0, 32'h124,   0,            4'b0000, 0,            2, 2));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'h12345678, 2, 2));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            2, 2));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 1, 32'hDEAABEEF, 0, 1, 1, 0, 32'h104,   0,            4'b0000, 0,            2, 3));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hDEAABEEF, 2, 3));
        tbl.push_back(mk(0, 0, 0,       0,            0, 0, 1, 32'h55555555, 0, 0, 0, 0, 0,         0,            4'b0000, 0,            2, 3));
        tbl.push_back(mk(0, 0, 0,       0,            0, 0, 0, 0,            0, 0, 0, 0, 0,         0,            4'b0000, 0,            2, 3));
        tbl.push_back(mk(1, 0, 32'h104, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hDEAABEEF, 2, 3));
        tbl.push_back(mk(1, 1, 32'h126, 32'h0000BEEF, 1, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            3, 3));
        tbl.push_back(mk(1, 1, 32'h126, 32'h0000BEEF, 1, 0, 1, 0,            0, 1, 1, 1, 32'h124,   32'hBEEF0000, 4'b1100, 0,            3, 3));
        tbl.push_back(mk(1, 1, 32'h126, 32'h0000BEEF, 1, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 0,            3, 3));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            3, 3));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 1, 32'hBEEF5678, 0, 1, 1, 0, 32'h124,   0,            4'b0000, 0,            3, 4));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'hBEEF5678, 3, 4));
        tbl.push_back(mk(1, 1, 32'h13C, 32'hCAFEF00D, 3, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            3, 4));
        tbl.push_back(mk(1, 1, 32'h13C, 32'hCAFEF00D, 3, 0, 1, 0,            0, 1, 1, 1, 32'h13C,   32'hCAFEF00D, 4'b1111, 0,            3, 4));
        tbl.push_back(mk(1, 1, 32'h13C, 32'hCAFEF00D, 3, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 0,            3, 4));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 1, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            3, 4));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            0, 1, 0, 0, 0,         0,            4'b0000, 0,            3, 4));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 1, 32'h0BADF00D, 0, 1, 1, 0, 32'h124,   0,            4'b0000, 0,            3, 5));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'h0BADF00D, 3, 5));
        tbl.push_back(mk(1, 0, 32'h124, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,         0,            4'b0000, 32'h0BADF00D, 3, 5));

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].fmt,
                  tbl[i].flush, tbl[i].ack, tbl[i].mrd);
            #1;
            chk($sformatf("v%0d.ready", i),     32'(bus.cpu_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("v%0d.stall", i),     32'(stall),           32'(tbl[i].stl));
            chk($sformatf("v%0d.mem_req", i),   32'(bus.mem_req_o),   32'(tbl[i].mrq));
            chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we_o),    32'(tbl[i].mwe));
            chk($sformatf("v%0d.mem_addr", i),  bus.mem_addr_o,       tbl[i].maddr);
            chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata_o,      tbl[i].mwd);
            chk($sformatf("v%0d.mem_be", i),    32'(bus.mem_be_o),    32'(tbl[i].be));
            chk($sformatf("v%0d.rdata", i),     bus.cpu_rdata_o,      tbl[i].rd);
            chk($sformatf("v%0d.hit_cnt", i),   32'(hit_cnt),         32'(tbl[i].hit));
            chk($sformatf("v%0d.miss_cnt", i),  32'(miss_cnt),        32'(tbl[i].miss));
            step();
        end

        // Slow memory: request must hold steady while ack is withheld; flush arrives mid-fetch.
        drive(1, 0, 32'h104, 0, 0, 0, 0, 0);
        #1;
        chk("slow.accept_stall", 32'(stall), 1);
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("slow.w%0d.mem_req", k),  32'(bus.mem_req_o), 1);
            chk($sformatf("slow.w%0d.mem_addr", k), bus.mem_addr_o, 32'h104);
            chk($sformatf("slow.w%0d.stall", k),    32'(stall), 1);
            step();
        end
        drive(1, 0, 32'h104, 0, 0, 1, 1, 32'h11112222);
        #1;
        chk("slow.ack_mem_req", 32'(bus.mem_req_o), 1);
        step();
        drive(1, 0, 32'h104, 0, 0, 0, 0, 0);
        #1;
        chk("slow.resp_ready", 32'(bus.cpu_ready_o), 1);
        chk("slow.resp_rdata", bus.cpu_rdata_o, 32'h11112222);
        chk("slow.resp_req_dropped", 32'(bus.mem_req_o), 0);
        step();
        #1;
        chk("pendflush.ready", 32'(bus.cpu_ready_o), 0);
        chk("pendflush.stall", 32'(stall), 1);
        step();

        // Reset in the middle of a refill.
        #1;
        chk("midrst.fetch_req", 32'(bus.mem_req_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst.mem_req", 32'(bus.mem_req_o), 0);
        chk("midrst.stall",   32'(stall), 0);
        chk("midrst.hit_cnt", 32'(hit_cnt), 0);
        chk("midrst.miss_cnt", 32'(miss_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h99999999);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst.late_ack_req", 32'(bus.mem_req_o), 0);
        chk("midrst.late_ack_ready", 32'(bus.cpu_ready_o), 0);
        drive(1, 0, 32'h124, 0, 0, 0, 0, 0);
        #1;
        chk("midrst.invalid_ready", 32'(bus.cpu_ready_o), 0);
        chk("midrst.invalid_stall", 32'(stall), 1);
        step();
        #1;
        chk("midrst.refill_req",  32'(bus.mem_req_o), 1);
        chk("midrst.refill_addr", bus.mem_addr_o, 32'h124);
        chk("midrst.miss_cnt1",   32'(miss_cnt), 1);
        drive(1, 0, 32'h124, 0, 0, 0, 1, 32'hA5A5A5A5);
        step();
        drive(1, 0, 32'h124, 0, 0, 0, 0, 0);
        #1;
        chk("midrst.resp_rdata", bus.cpu_rdata_o, 32'hA5A5A5A5);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Controller for the direct-mapped data cache built from the shared CacheBlock record: 8 sets, one 32-bit word per block. Sits between the memory stage and main data memory. Serves read hits with zero added latency, refills on read miss, writes through every store with byte-lane masking, and stalls the pipeline while memory is busy. Also owns cache invalidation and hit/miss performance counters.

Parameters:
DATA_WIDTH, 32, word/address width (package)
SET_SIZE, 3, index bits; sets = 2**SET_SIZE = 8 (package)
TAG_WIDTH, DATA_WIDTH-SET_SIZE-2 = 27, tag bits (package)
CNT_WIDTH, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cpu_req_i  in  1  memory-stage access valid
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  store data, right-aligned
cpu_byte_i  in  2  byte_format: Word=00, HalfWord=01, Byte=10
flush_i  in  1  invalidate all sets
cpu_rdata_o  out  32  full aligned word; extraction done downstream
cpu_ready_o  out  1  access completes this cycle
stall_o  out  1  freeze PC and pipeline registers
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_addr_o  out  32  word-aligned address, bits [1:0] = 00
mem_wdata_o  out  32  lane-shifted store data
mem_be_o  out  4  byte enables
mem_ack_i  in  1  memory completes request
mem_rdata_i  in  32  refill word, valid with mem_ack_i
hit_cnt_o  out  CNT_WIDTH  saturating load-hit count
miss_cnt_o  out  CNT_WIDTH  saturating load-miss count

Behaviour:
- Address split: offset [1:0], index [4:2], tag [31:5].
- Storage: 8 CacheBlock entries. Tag compare is combinational against cpu_addr_i.
- Reset: all V=0. State=IDLE. Counters=0. All outputs 0, including mem_req_o and stall_o.
- FSM states:
  - IDLE:
    - Load hit: cpu_ready_o=1 and cpu_rdata_o=Cache_Data in the same cycle; stall_o=0; hit_cnt_o+1.
    - Load miss: latch request, go to FETCH; miss_cnt_o+1; stall_o=1.
    - Store: latch request, go to WRITE; stall_o=1.
    - No request: outputs idle.
  - FETCH:
    - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,00}.
    - On mem_ack_i: write block {V=1, tag, mem_rdata_i}, capture word, go to RESP.
  - WRITE:
    - mem_req_o=1, mem_we_o=1, with be and lane-shifted data.
    - On mem_ack_i: if the latched address hits, merge enabled bytes into Cache_Data. Write miss does not allocate. Go to RESP.
  - RESP:
    - cpu_ready_o=1, stall_o=0; cpu_rdata_o = refilled word (load) or 0 (store). Go to IDLE.
    - Pipeline advances on this edge; cpu_req_i is not sampled in RESP.
- stall_o = 1 in FETCH and WRITE, and in IDLE when cpu_req_i is set and the access is not a load hit.
- Miss latency: request accepted cycle N, mem_req_o high N+1. Ack at cycle M gives RESP at M+1.
- Memory handshake:
  - mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o stay stable until the cycle mem_ack_i=1. mem_req_o drops the next cycle.
  - mem_ack_i is ignored when mem_req_o=0.
- Byte enables and lane shift:
  - Word: be=1111, data unshifted.
  - HalfWord: be = 0011 if addr[1]=0, else 1100; data shifted 16 when addr[1]=1. addr[0] is ignored.
  - Byte: be = 0001 << addr[1:0]; data[7:0] moved to that lane.
  - Encoding 11 is treated as Word.
- flush_i:
  - In IDLE: clears every V on the next edge and takes priority over cpu_req_i. stall_o=1 that cycle; the request is served the following cycle.
  - Outside IDLE: set a pending flag, applied on the RESP->IDLE edge.
- Counters: saturate at all-ones; no wrap.
- Reset mid-transaction: back to IDLE with all V cleared, mem_req_o=0 next cycle. A late mem_ack_i is ignored.

Decomposition:
- types_pkg already holds CacheBlock, byte_format, DATA_WIDTH, SET_SIZE.
- Add to types_pkg: typedef enum dcache_state {IDLE, FETCH, WRITE, RESP} and CNT_WIDTH.
- One sub-module, byte_lane_gen: combinational cpu_byte_i, addr[1:0], wdata -> be, shifted data. Reused by the merge logic and the memory port.

Test Plan:
- Reset, then load 0x0000_0104 -> stall_o=1, mem_req_o next cycle at 0x104. Ack with 0xDEADBEEF -> RESP cpu_rdata_o=0xDEADBEEF, miss_cnt_o=1.
- Reload 0x104 -> cpu_ready_o same cycle, data 0xDEADBEEF, stall_o=0, hit_cnt_o=1, no mem_req_o.
- Byte store 0xAA to 0x106 (hit) -> mem_be_o=0100, mem_wdata_o=0x00AA0000. After ack, load 0x106 hits with 0xDEAABEEF.
- Load 0x124 (same index 1, tag differs) -> miss, refill with 0x12345678. Then load 0x104 -> miss again (evicted).
- Delay mem_ack_i 5 cycles -> mem_req_o and mem_addr_o stay stable, stall_o high throughout; stray ack while idle has no effect.
- flush_i in IDLE then load 0x124 -> miss. Assert rst during FETCH -> mem_req_o=0 next cycle, all blocks invalid, counters 0.
